// File: rtl/pic_q_cycle_sequencer_if.sv
// Sequencer-to-datapath bundle: stall, IR contents and skip condition in;
// Q phase, one-clock control strobes, flush status and retire count out.
interface pic_q_cycle_sequencer_if #(
  parameter int INSTR_W  = 14,
  parameter int RETIRE_W = 16
);
  logic                stall;
  logic [INSTR_W-1:0]  instr_current;
  logic                skip_taken;
  logic [3:0]          q_phase;
  logic                data_rd_en;
  logic                alu_en;
  logic                data_wr_en;
  logic                incr_pc_en;
  logic                pc_load_en;
  logic                instr_rd_en;
  logic                flush_active;
  logic [RETIRE_W-1:0] retired_count;

  modport master (
    input  stall, instr_current, skip_taken,
    output q_phase, data_rd_en, alu_en, data_wr_en, incr_pc_en,
           pc_load_en, instr_rd_en, flush_active, retired_count
  );

  modport slave (
    output stall, instr_current, skip_taken,
    input  q_phase, data_rd_en, alu_en, data_wr_en, incr_pc_en,
           pc_load_en, instr_rd_en, flush_active, retired_count
  );
endinterface

// File: rtl/pic_q_cycle_sequencer.sv
// Four-phase instruction-cycle sequencer for the PIC16F-style core: drives the
// Q1..Q4 phase, datapath strobes, and forced-NOP flushes after branches/skips.
module pic_q_cycle_sequencer #(
  parameter int INSTR_W    = 14,
  parameter int CLKS_PER_Q = 1,
  parameter int RETIRE_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  pic_q_cycle_sequencer_if.master  bus
);
  localparam int DIV_W = (CLKS_PER_Q > 1) ? $clog2(CLKS_PER_Q) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_Q - 1);

  typedef enum logic [3:0] {
    Q1 = 4'b0001,
    Q2 = 4'b0010,
    Q3 = 4'b0100,
    Q4 = 4'b1000
  } phase_e;

  phase_e              phase_q, phase_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic                flush_pending_q, flush_pending_d;
  logic                flush_active_q, flush_active_d;
  logic [RETIRE_W-1:0] retired_q, retired_d;
  logic                is_branch;
  logic                last_clk;
  logic                advance;
  logic                fire;

  // GOTO/CALL, RETURN, RETFIE and RETLW all redirect the PC at Q4.
  if (INSTR_W == 14) begin : g_decode
    assign is_branch = (bus.instr_current[13:12] == 2'b10)  ||
                       (bus.instr_current == 14'h0008)      ||
                       (bus.instr_current == 14'h0009)      ||
                       (bus.instr_current[13:10] == 4'b1101);
  end else begin : g_no_decode
    assign is_branch = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q           <= '0;
      phase_q         <= Q1;
      flush_pending_q <= 1'b0;
      flush_active_q  <= 1'b1;
      retired_q       <= '0;
    end else begin
      div_q           <= div_d;
      phase_q         <= phase_d;
      flush_pending_q <= flush_pending_d;
      flush_active_q  <= flush_active_d;
      retired_q       <= retired_d;
    end
  end

  always_comb begin
    last_clk        = (div_q == DIV_LAST);
    advance         = last_clk && !bus.stall;
    div_d           = div_q;
    phase_d         = phase_q;
    flush_pending_d = flush_pending_q;
    flush_active_d  = flush_active_q;
    retired_d       = retired_q;

    if (!bus.stall) begin
      div_d = last_clk ? '0 : div_q + 1'b1;
    end

    if (advance) begin
      unique case (phase_q)
        Q1: phase_d = Q2;
        Q2: phase_d = Q3;
        Q3: begin
          phase_d = Q4;
          if (!flush_active_q && bus.skip_taken) flush_pending_d = 1'b1;
        end
        Q4: begin
          phase_d = Q1;
          // A branch raises the flush on this same clock, so fold it in directly.
          flush_active_d  = flush_pending_q || (!flush_active_q && is_branch);
          flush_pending_d = 1'b0;
          if (!flush_active_q) retired_d = retired_q + 1'b1;
        end
        default: phase_d = Q1;
      endcase
    end
  end

  // Strobes are combinational so a stall on a last clock blocks them immediately.
  assign fire = advance && rst_n;

  assign bus.data_rd_en    = fire && (phase_q == Q2) && !flush_active_q;
  assign bus.alu_en        = fire && (phase_q == Q3) && !flush_active_q;
  assign bus.data_wr_en    = fire && (phase_q == Q4) && !flush_active_q;
  assign bus.pc_load_en    = fire && (phase_q == Q4) && !flush_active_q && is_branch;
  assign bus.incr_pc_en    = fire && (phase_q == Q4) && !(!flush_active_q && is_branch);
  assign bus.instr_rd_en   = fire && (phase_q == Q4);
  assign bus.q_phase       = phase_q;
  assign bus.flush_active  = flush_active_q;
  assign bus.retired_count = retired_q;
endmodule

// File: tb/tb_pic_q_cycle_sequencer.sv
// Bench for pic_q_cycle_sequencer: two instances (1 and 3 clocks per Q phase)
// share directed-then-random stimulus and are checked against a tick-count model.
module tb_pic_q_cycle_sequencer;
  logic        clk = 1'b0;
  logic        rst_n, stall, skip;
  logic [13:0] instr;
  logic [5:0]  st1;

  always #5 clk = ~clk;

  pic_q_cycle_sequencer_if #(.INSTR_W(14), .RETIRE_W(16)) bus1 ();
  pic_q_cycle_sequencer_if #(.INSTR_W(14), .RETIRE_W(4))  bus3 ();

  assign bus1.stall         = stall;
  assign bus1.instr_current = instr;
  assign bus1.skip_taken    = skip;
  assign bus3.stall         = stall;
  assign bus3.instr_current = instr;
  assign bus3.skip_taken    = skip;

  pic_q_cycle_sequencer #(.INSTR_W(14), .CLKS_PER_Q(1), .RETIRE_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1));
  pic_q_cycle_sequencer #(.INSTR_W(14), .CLKS_PER_Q(3), .RETIRE_W(4)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3));

  // Model state: clocks elapsed in the current instruction cycle, flush flags, retire count.
  int          m_tick [2];
  bit          m_fa   [2];
  bit          m_pend [2];
  int unsigned m_ret  [2];
  int          cpq_of [2] = '{1, 3};
  int          rw_of  [2] = '{16, 4};
  int          checks = 0, passed = 0, fails = 0;

  function automatic bit model_branch(logic [13:0] w);
    return (w[13:12] == 2'b10) || (w == 14'h0008) || (w == 14'h0009) || (w[13:10] == 4'b1101);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cmp(int d, logic [3:0] qp, logic [5:0] st, logic fa, logic [15:0] ret);
    int          cpq  = cpq_of[d];
    int          ph   = (m_tick[d] / cpq) % 4;
    bit          last = (m_tick[d] % cpq) == cpq - 1;
    bit          go   = last && !stall && rst_n;
    bit          nf   = !m_fa[d];
    bit          br   = model_branch(instr);
    int unsigned mask = (32'd1 << rw_of[d]) - 1;
    logic [5:0]  es;
    logic [3:0]  eq;
    es[5] = go && ph == 1 && nf;
    es[4] = go && ph == 2 && nf;
    es[3] = go && ph == 3 && nf;
    es[2] = go && ph == 3 && !(nf && br);
    es[1] = go && ph == 3 && nf && br;
    es[0] = go && ph == 3;
    eq    = 4'(1 << ph);
    chk($sformatf("cpq%0d q_phase", cpq), 32'(qp), 32'(eq));
    chk($sformatf("cpq%0d strobes", cpq), 32'(st), 32'(es));
    chk($sformatf("cpq%0d flush_active", cpq), 32'(fa), 32'(m_fa[d]));
    chk($sformatf("cpq%0d retired_count", cpq), 32'(ret), m_ret[d] & mask);
  endtask

  task automatic model_update(int d);
    int          cpq  = cpq_of[d];
    int          ph   = (m_tick[d] / cpq) % 4;
    bit          last = (m_tick[d] % cpq) == cpq - 1;
    int unsigned mask = (32'd1 << rw_of[d]) - 1;
    if (!rst_n) begin
      m_tick[d] = 0; m_fa[d] = 1'b1; m_pend[d] = 1'b0; m_ret[d] = 0;
    end else if (!stall) begin
      if (last && ph == 2 && !m_fa[d] && skip) m_pend[d] = 1'b1;
      if (last && ph == 3) begin
        if (!m_fa[d] && model_branch(instr)) m_pend[d] = 1'b1;
        if (!m_fa[d]) m_ret[d] = (m_ret[d] + 1) & mask;
        m_fa[d]   = m_pend[d];
        m_pend[d] = 1'b0;
      end
      m_tick[d] = (m_tick[d] + 1) % (4 * cpq);
    end
  endtask

  task automatic tick_clk(bit check = 1'b1);
    @(negedge clk);
    st1 = {bus1.data_rd_en, bus1.alu_en, bus1.data_wr_en,
           bus1.incr_pc_en, bus1.pc_load_en, bus1.instr_rd_en};
    if (check) begin
      cmp(0, bus1.q_phase, st1, bus1.flush_active, bus1.retired_count);
      cmp(1, bus3.q_phase,
          {bus3.data_rd_en, bus3.alu_en, bus3.data_wr_en,
           bus3.incr_pc_en, bus3.pc_load_en, bus3.instr_rd_en},
          bus3.flush_active, 16'(bus3.retired_count));
    end
    @(posedge clk);
    model_update(0);
    model_update(1);
    #1;
  endtask

  initial begin
    int sel;
    rst_n = 1'b0; stall = 1'b1; skip = 1'b0; instr = 14'h0000;
    tick_clk(1'b0);
    tick_clk();                          // reset held with stall high

    rst_n = 1'b1; stall = 1'b0;
    repeat (12) tick_clk();
    chk("nop retired after 12", 32'(bus1.retired_count), 32'd2);
    chk("cpq3 retired after 12", 32'(bus3.retired_count), 32'd0);
    chk("cpq3 second cycle live", 32'(bus3.flush_active), 32'd0);

    instr = 14'h2805;
    repeat (4) tick_clk();
    chk("goto q4 strobes", 32'(st1), 32'b001011);
    instr = 14'h0000;
    tick_clk();
    chk("goto flush_active", 32'(bus1.flush_active), 32'd1);
    repeat (3) tick_clk();
    chk("goto flushed q4 strobes", 32'(st1), 32'b000101);
    chk("goto retired", 32'(bus1.retired_count), 32'd3);

    instr = 14'h1C03; skip = 1'b1;
    repeat (4) tick_clk();
    chk("skip q4 strobes", 32'(st1), 32'b001101);
    instr = 14'h0000;
    repeat (4) tick_clk();
    chk("skip flushed q4 strobes", 32'(st1), 32'b000101);
    skip = 1'b0;
    tick_clk();
    chk("no second flush", 32'(bus1.flush_active), 32'd0);
    repeat (3) tick_clk();
    chk("skip retired", 32'(bus1.retired_count), 32'd5);

    tick_clk();
    stall = 1'b1;
    repeat (5) tick_clk();
    chk("stalled strobes", 32'(st1), 32'd0);
    stall = 1'b0;
    tick_clk();
    chk("rd after stall", 32'(st1), 32'b100000);
    repeat (2) tick_clk();
    chk("post-stall q4 strobes", 32'(st1), 32'b001101);
    chk("post-stall retired", 32'(bus1.retired_count), 32'd6);

    skip = 1'b1; instr = 14'h2805;
    repeat (3) tick_clk();
    rst_n = 1'b0;
    tick_clk();
    chk("aborted q4 strobes", 32'(st1), 32'd0);
    rst_n = 1'b1; skip = 1'b0; instr = 14'h0000;
    chk("reset q_phase", 32'(bus1.q_phase), 32'b0001);
    chk("reset flush_active", 32'(bus1.flush_active), 32'd1);
    chk("reset retired", 32'(bus1.retired_count), 32'd0);
    chk("cpq3 reset q_phase", 32'(bus3.q_phase), 32'b0001);

    repeat (600) begin
      rst_n = ($urandom_range(0, 149) != 0);
      stall = ($urandom_range(0, 9) == 0);
      skip  = 1'($urandom_range(0, 1));
      sel   = $urandom_range(0, 5);
      case (sel)
        0:       instr = {2'b10, 12'($urandom)};
        1:       instr = 14'h0008;
        2:       instr = 14'h0009;
        3:       instr = {4'b1101, 10'($urandom)};
        default: instr = 14'($urandom);
      endcase
      tick_clk();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
